// File: rtl/ex_flag_if.sv
// Execute-stage bundle: ALU result and branch request in, EX/WB register,
// flags and branch resolution out.
interface ex_flag_if #(
  parameter int WIDTH = 16
);
  logic             ex_vld;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_dst;
  logic             alu_ov;
  logic             alu_zr;
  logic             alu_n;
  logic [3:0]       ex_rd;
  logic             ex_we;
  logic             br_vld;
  logic [2:0]       br_cc;

  logic [WIDTH-1:0] wb_data;
  logic [3:0]       wb_rd;
  logic             wb_we;
  logic             flag_zr;
  logic             flag_ov;
  logic             flag_n;
  logic             br_taken;
  logic             br_done;

  modport master (
    output ex_vld, alu_op, alu_dst, alu_ov, alu_zr, alu_n, ex_rd, ex_we,
           br_vld, br_cc,
    input  wb_data, wb_rd, wb_we, flag_zr, flag_ov, flag_n, br_taken, br_done
  );

  modport slave (
    input  ex_vld, alu_op, alu_dst, alu_ov, alu_zr, alu_n, ex_rd, ex_we,
           br_vld, br_cc,
    output wb_data, wb_rd, wb_we, flag_zr, flag_ov, flag_n, br_taken, br_done
  );
endinterface

// File: rtl/ex_flag_stage.sv
// Execute-stage back end: EX/WB pipeline register, architectural flags and
// branch resolution with same-cycle bypass of the flags being written.
module ex_flag_stage #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       flush,
  ex_flag_if.slave   bus
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_SLL = 3'd3;
  localparam logic [2:0] OP_SRL = 3'd4;
  localparam logic [2:0] OP_SRA = 3'd5;

  logic acc;
  logic bacc;
  logic nzr;
  logic nov;
  logic nn;
  logic cond;

  assign acc  = bus.ex_vld & ~stall & ~flush;
  assign bacc = bus.br_vld & ~stall & ~flush;

  // Flags as they will be after this edge; branches evaluate on these so an
  // ALU op and a branch in the same cycle resolve ALU-first.
  always_comb begin
    nzr = bus.flag_zr;
    nov = bus.flag_ov;
    nn  = bus.flag_n;
    if (acc) begin
      case (bus.alu_op)
        OP_ADD, OP_SUB: begin
          nzr = bus.alu_zr;
          nov = bus.alu_ov;
          nn  = bus.alu_n;
        end
        OP_XOR, OP_SLL, OP_SRL, OP_SRA: nzr = bus.alu_zr;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (bus.br_cc)
      3'd0:    cond = ~nzr;
      3'd1:    cond = nzr;
      3'd2:    cond = ~nzr & ~nn;
      3'd3:    cond = nn;
      3'd4:    cond = nzr | ~nn;
      3'd5:    cond = nzr | nn;
      3'd6:    cond = nov;
      default: cond = 1'b1;
    endcase
  end

  // Flush overrides stall for the valid-type outputs only; data and flags
  // never move while flush is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wb_data  <= '0;
      bus.wb_rd    <= '0;
      bus.wb_we    <= 1'b0;
      bus.flag_zr  <= 1'b0;
      bus.flag_ov  <= 1'b0;
      bus.flag_n   <= 1'b0;
      bus.br_taken <= 1'b0;
      bus.br_done  <= 1'b0;
    end else if (flush) begin
      bus.wb_we    <= 1'b0;
      bus.br_taken <= 1'b0;
      bus.br_done  <= 1'b0;
    end else if (!stall) begin
      if (acc) begin
        bus.wb_data <= bus.alu_dst;
        bus.wb_rd   <= bus.ex_rd;
        bus.wb_we   <= bus.ex_we;
      end else begin
        bus.wb_we   <= 1'b0;
      end
      bus.flag_zr  <= nzr;
      bus.flag_ov  <= nov;
      bus.flag_n   <= nn;
      bus.br_done  <= bacc;
      bus.br_taken <= bacc & cond;
    end
  end

endmodule

// File: tb/tb_ex_flag_stage.sv
// Directed bench for ex_flag_stage: reset, flag rules, bypass, branch
// conditions, stall and flush, with hand-computed expectations.
module tb_ex_flag_stage;

  localparam int WIDTH = 16;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd2, SRA = 3'd5,
                         LLB = 3'd6, LHB = 3'd7;

  logic clk = 1'b0;
  logic rst_n;
  logic stall;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  ex_flag_if #(.WIDTH(WIDTH)) bus ();

  ex_flag_stage #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stall),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic v, input logic [2:0] op,
                     input logic [15:0] d, input logic ov, input logic zr,
                     input logic n, input logic [3:0] rd, input logic we);
    bus.ex_vld  = v;
    bus.alu_op  = op;
    bus.alu_dst = d;
    bus.alu_ov  = ov;
    bus.alu_zr  = zr;
    bus.alu_n   = n;
    bus.ex_rd   = rd;
    bus.ex_we   = we;
  endtask

  task automatic br(input logic v, input logic [2:0] cc);
    bus.br_vld = v;
    bus.br_cc  = cc;
  endtask

  function automatic logic [2:0] flags();
    return {bus.flag_zr, bus.flag_ov, bus.flag_n};
  endfunction

  logic [7:0] cc_exp;

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    alu(1'b0, ADD, 16'h0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    br(1'b0, 3'd0);

    #12;
    chk("rst_wb_data", 32'(bus.wb_data), 32'h0);
    chk("rst_wb_we", 32'(bus.wb_we), 32'h0);
    chk("rst_flags", 32'(flags()), 32'h0);
    chk("rst_br_done", 32'(bus.br_done), 32'h0);
    #10 rst_n = 1'b1;

    // Load something nonzero everywhere, then reset mid-stream
    alu(1'b1, ADD, 16'hBEEF, 1'b0, 1'b0, 1'b1, 4'd5, 1'b1);
    br(1'b1, 3'd7);
    tick();
    chk("pre_wb_data", 32'(bus.wb_data), 32'hBEEF);
    chk("pre_wb_rd", 32'(bus.wb_rd), 32'd5);
    chk("pre_flags", 32'(flags()), 32'b001);
    chk("pre_br", 32'({bus.br_done, bus.br_taken}), 32'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_wb_data", 32'(bus.wb_data), 32'h0);
    chk("async_rst_wb_rd", 32'(bus.wb_rd), 32'h0);
    chk("async_rst_wb_we", 32'(bus.wb_we), 32'h0);
    chk("async_rst_flags", 32'(flags()), 32'h0);
    chk("async_rst_br", 32'({bus.br_done, bus.br_taken}), 32'b00);
    tick();
    chk("rst_held", 32'(bus.wb_data), 32'h0);
    rst_n = 1'b1;
    alu(1'b1, ADD, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1);
    br(1'b0, 3'd0);
    tick();
    chk("post_rst_wb_data", 32'(bus.wb_data), 32'h0001);
    chk("post_rst_wb_we", 32'(bus.wb_we), 32'h1);
    chk("post_rst_flags", 32'(flags()), 32'b000);

    // Flag update rules
    alu(1'b1, SUB, 16'h8000, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1);
    tick();
    chk("sub_flags", 32'(flags()), 32'b011);
    alu(1'b1, XOR, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1);
    tick();
    chk("xor_flags", 32'(flags()), 32'b111);
    alu(1'b1, LLB, 16'h0055, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1);
    tick();
    chk("llb_flags", 32'(flags()), 32'b111);
    chk("llb_wb_data", 32'(bus.wb_data), 32'h0055);

    // Bypass: Sub sets zr in the same cycle the branch resolves
    alu(1'b1, ADD, 16'h9000, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1);
    tick();
    chk("bp_setup_flags", 32'(flags()), 32'b011);
    alu(1'b1, SUB, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1);
    br(1'b1, 3'd1);
    tick();
    chk("bp_eq", 32'({bus.br_done, bus.br_taken}), 32'b11);
    chk("bp_eq_flags", 32'(flags()), 32'b100);
    alu(1'b1, ADD, 16'h9000, 1'b1, 1'b0, 1'b1, 4'd1, 1'b1);
    br(1'b0, 3'd0);
    tick();
    chk("no_branch_done", 32'({bus.br_done, bus.br_taken}), 32'b00);
    alu(1'b1, SUB, 16'h0000, 1'b0, 1'b1, 1'b0, 4'd1, 1'b1);
    br(1'b1, 3'd0);
    tick();
    chk("bp_neq", 32'({bus.br_done, bus.br_taken}), 32'b10);

    // All conditions with flags zr=0 ov=1 n=1
    alu(1'b1, ADD, 16'hA5A5, 1'b1, 1'b0, 1'b1, 4'd7, 1'b1);
    br(1'b0, 3'd0);
    tick();
    chk("cc_setup_flags", 32'(flags()), 32'b011);
    alu(1'b0, ADD, 16'h1111, 1'b0, 1'b1, 1'b0, 4'd9, 1'b1);
    cc_exp = 8'b1110_1001;
    for (int i = 0; i < 8; i++) begin
      br(1'b1, 3'(i));
      tick();
      chk($sformatf("cc%0d_taken", i), 32'({bus.br_done, bus.br_taken}),
          32'({1'b1, cc_exp[i]}));
    end
    chk("idle_wb_we", 32'(bus.wb_we), 32'h0);
    chk("idle_wb_data", 32'(bus.wb_data), 32'hA5A5);
    chk("idle_wb_rd", 32'(bus.wb_rd), 32'd7);
    chk("idle_flags", 32'(flags()), 32'b011);

    // Stall holds everything
    alu(1'b1, ADD, 16'h1234, 1'b0, 1'b0, 1'b0, 4'd3, 1'b1);
    br(1'b1, 3'd7);
    tick();
    chk("stall_setup_wb_data", 32'(bus.wb_data), 32'h1234);
    chk("stall_setup_flags", 32'(flags()), 32'b000);
    stall = 1'b1;
    alu(1'b1, SUB, 16'hFFFF, 1'b1, 1'b1, 1'b1, 4'd8, 1'b0);
    br(1'b1, 3'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall%0d_wb_data", i), 32'(bus.wb_data), 32'h1234);
      chk($sformatf("stall%0d_wb_we", i), 32'(bus.wb_we), 32'h1);
      chk($sformatf("stall%0d_flags", i), 32'(flags()), 32'b000);
      chk($sformatf("stall%0d_br", i), 32'({bus.br_done, bus.br_taken}), 32'b11);
    end

    // Flush under stall clears valids only
    flush = 1'b1;
    alu(1'b1, ADD, 16'h4321, 1'b0, 1'b1, 1'b0, 4'd4, 1'b1);
    br(1'b1, 3'd7);
    tick();
    chk("fs_wb_we", 32'(bus.wb_we), 32'h0);
    chk("fs_br", 32'({bus.br_done, bus.br_taken}), 32'b00);
    chk("fs_flags", 32'(flags()), 32'b000);
    chk("fs_wb_data", 32'(bus.wb_data), 32'h1234);
    chk("fs_wb_rd", 32'(bus.wb_rd), 32'd3);

    // Flush without stall behaves the same
    stall = 1'b0;
    alu(1'b1, SUB, 16'h5555, 1'b1, 1'b1, 1'b1, 4'd6, 1'b1);
    tick();
    chk("f_wb_data", 32'(bus.wb_data), 32'h1234);
    chk("f_flags", 32'(flags()), 32'b000);
    chk("f_br_done", 32'(bus.br_done), 32'h0);

    // Resume: Lhb leaves flags, Sra updates zr only
    flush = 1'b0;
    br(1'b0, 3'd0);
    alu(1'b1, LHB, 16'h7700, 1'b1, 1'b1, 1'b1, 4'd10, 1'b0);
    tick();
    chk("lhb_wb_data", 32'(bus.wb_data), 32'h7700);
    chk("lhb_wb_we", 32'(bus.wb_we), 32'h0);
    chk("lhb_flags", 32'(flags()), 32'b000);
    alu(1'b1, SRA, 16'h0000, 1'b1, 1'b1, 1'b1, 4'd11, 1'b1);
    tick();
    chk("sra_flags", 32'(flags()), 32'b100);
    chk("sra_wb_rd", 32'(bus.wb_rd), 32'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_flag_stage.md
# ex_flag_stage

Execute-stage back end of the 16-bit processor datapath, directly downstream of the saturating ALU. It registers the ALU result into the EX/WB pipeline register and maintains the architectural flag register (ZR, OV, N) under per-opcode update rules. It also resolves conditional branches against the flags, with same-cycle bypass from the ALU. Stall and flush from the hazard unit are honoured on every register it owns.

## Interface
- WIDTH, 16, datapath width; must match the ALU result width.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all state; inputs ignored.
- flush  in  1  kill the instruction presented this cycle.
- ex_vld  in  1  ALU instruction valid this cycle.
- alu_op  in  3  ALU opcode: 0 Add, 1 Sub, 2 Xor, 3 Sll, 4 Srl, 5 Sra, 6 Llb, 7 Lhb.
- alu_dst  in  WIDTH  ALU result.
- alu_ov, alu_zr, alu_n  in  1 each  ALU flag outputs.
- ex_rd  in  4  destination register index.
- ex_we  in  1  instruction writes the register file.
- br_vld  in  1  branch instruction valid this cycle.
- br_cc  in  3  branch condition code.
- wb_data  out  WIDTH  registered result; reset 0.
- wb_rd  out  4  registered destination; reset 0.
- wb_we  out  1  registered write enable; reset 0.
- flag_zr, flag_ov, flag_n  out  1 each  architectural flags; reset 0.
- br_taken  out  1  registered branch decision; reset 0.
- br_done  out  1  registered: a branch resolved last cycle; reset 0.

## Operation
- Accept: `acc = ex_vld & ~stall & ~flush`. Branch accept: `bacc = br_vld & ~stall & ~flush`.
- Pipeline register:
  - On `acc`: wb_data <= alu_dst, wb_rd <= ex_rd, wb_we <= ex_we.
  - On `~stall & ~acc`: wb_we <= 0. wb_data and wb_rd hold.
  - On stall: everything holds.
- Flag update on `acc`, by alu_op:
  - Add, Sub: ZR, OV and N all load.
  - Xor, Sll, Srl, Sra: ZR loads; OV and N hold.
  - Llb, Lhb: no flag changes.
- Next-flag values (nzr, nov, nn) are the values the flag register will hold after this edge. They are computed combinationally from the rules above.
- Branch conditions are evaluated on the next-flag values. An ALU instruction and a branch accepted in the same cycle are ordered ALU-first.

  | br_cc | Condition | Taken when |
  |---|---|---|
  | 0 | NEQ | ~nzr |
  | 1 | EQ | nzr |
  | 2 | GT | ~nzr & ~nn |
  | 3 | LT | nn |
  | 4 | GTE | nzr \| ~nn |
  | 5 | LTE | nzr \| nn |
  | 6 | OVFL | nov |
  | 7 | UNCOND | 1 |

- Branch outputs:
  - On `bacc`: br_done <= 1, br_taken <= condition.
  - On `~stall & ~bacc`: both go to 0.
  - On stall: both hold.
- Priority: rst_n > flush > stall > normal.
  - Flush with stall asserted still clears wb_we, br_done and br_taken.
  - Flush never alters the flags, wb_data or wb_rd.
- Reset asserted mid-operation clears all outputs asynchronously. The first accept after rst_n deasserts behaves normally.

## Timing
- Latency is one cycle from accept to wb_* and flag_* outputs, and one cycle from branch accept to br_taken/br_done.
- Back-to-back accepts are supported every cycle. Throughput is 1 instruction/cycle.
- Flags written in cycle N are visible on flag_* in cycle N+1. A branch in cycle N sees them through the bypass.
- br_taken is meaningful only while br_done=1.

## Test plan
- **Reset:** hold rst_n=0 mid-stream with ex_vld=1 -> all outputs 0 immediately. Release -> an Add of 0x0001 yields wb_data=0x0001, wb_we=1, flags zr=0 ov=0 n=0.
- **Flag rules:** Sub with alu_ov=1, alu_n=1, alu_zr=0, then Xor with alu_zr=1, alu_n=0, then Llb with alu_zr=0 -> flags after each are (0,1,1), (1,1,1), (1,1,1).
- **Bypass:** in one cycle, Sub with alu_zr=1 plus br_vld with br_cc=1 -> next cycle br_done=1, br_taken=1.
  - Same with br_cc=0 -> br_taken=0.
  - Previous flag value is zr=0.
- **All conditions:** with flags held at zr=0, ov=1, n=1, sweep br_cc 0..7 -> br_taken = 1,0,0,1,0,1,1,1.
- **Stall:** Add 0x1234 accepted, then stall=1 for 3 cycles with new ex_vld inputs -> wb_data stays 0x1234, wb_we stays 1, flags unchanged.
- **Flush:** stall=1 and flush=1 with ex_vld=1, br_vld=1, Add alu_zr=1 -> wb_we=0, br_done=0, zr unchanged, wb_data unchanged.
